muldiv_sched: RTL and testbench
===============================

# muldiv_sched

Sequencer and owner of the HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. It accepts a multiply or divide issued from decode, runs an iterative 32-step shift-add multiply or restoring divide, and writes HI/LO on completion. While it is busy it raises a pipeline stall to any instruction that touches HI/LO. An exception flush cancels an in-flight operation without committing a result.

## Interface
No parameters; all widths are fixed at 32 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; synchronous and active-low
- start  in  1  issue of MULT/MULTU/DIV/DIVU from decode
- ALU2Op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- A  in  32  rs operand (multiplicand / dividend)
- B  in  32  rt operand (multiplier / divisor)
- mt_en  in  1  MTHI/MTLO write enable
- mt_hi  in  1  1 writes HI, 0 writes LO
- mt_data  in  32  MTHI/MTLO data
- RHL_visit  in  1  instruction in decode accesses HI/LO
- RHLSel_Rd  in  1  read select: 1 HI, 0 LO
- flush  in  1  exception/eret flush; cancels the operation
- rd_data  out  32  combinational read: RHLSel_Rd ? HI : LO
- HI, LO  out  32  architectural registers
- busy  out  1  state ≠ IDLE
- stall  out  1  RHL_visit & busy
- done  out  1  one-cycle pulse after a committed HI/LO write from mul/div

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 and flush=0: latch the operation, |A| and |B| (magnitudes only for signed ops), and the operand signs; cnt←0; go to CALC.
  - start while flush=1: ignored.
- CALC: one iteration per edge; cnt increments.
  - Multiply: 64-bit accumulator; if multiplier bit[cnt] is set, add the shifted multiplicand.
  - Divide: restoring division. Shift the remainder left by one and bring in the next dividend bit. Trial-subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1.
  - After the iteration with cnt=31: go to FIX.
- FIX (sign correction and commit):
  - MULT: negate the 64-bit product if the operand signs differ. {HI,LO}←product.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign. LO←quotient, HI←remainder.
  - Unsigned ops: no correction.
  - Divisor 0: no HI/LO write, but done still pulses. Latency is unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
  - Go to IDLE.
- mt_en in IDLE: writes the selected register at the edge.
- start or mt_en outside IDLE: ignored. Decode cannot issue these because stall holds it.
- flush in CALC/FIX: go to IDLE at that edge; no HI/LO write; done stays 0. flush has priority over start, mt_en and commit.
- Simultaneous start and mt_en in IDLE: mt_en writes at that edge; the mul/div result overwrites it later.

## Timing
- Reset (rst=0 at an edge): state=IDLE, cnt=0, HI=0, LO=0, done=0. Hence busy=0 and stall=0. Reset mid-operation aborts it with no commit.
- Start accepted at edge k:
  - CALC for the edges k+1 … k+32.
  - FIX commits at edge k+33.
  - busy=1 from after edge k through edge k+33 (33 cycles).
  - New HI/LO visible after edge k+33.
  - done=1 for the cycle after edge k+33 (k+34).
- A new start can be accepted at edge k+34 at the earliest; back-to-back issue gives 34 cycles per op.
- rd_data, busy and stall are combinational from registered state; no read-after-commit hazard, since stall blocks MFHI/MFLO until busy falls.
- MTHI/MTLO latency: 1 edge.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after edge k+33, HI=0xFFFFFFFE and LO=0x00000001; busy high for exactly 33 cycles; done pulses once at k+34.
- MULT A=0xFFFFFFFD (−3), B=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 with prior HI=0x11, LO=0x22 → HI/LO unchanged, done pulses at k+34; then DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MULT issued, flush asserted in CALC at cnt=10 → IDLE next edge, busy=0, HI/LO unchanged, no done; start in the same cycle as flush → ignored.
- MFHI in decode (RHL_visit=1) during busy → stall=1 every busy cycle, 0 the cycle after commit; rd_data then equals the new HI.
- MTLO 0xDEADBEEF in IDLE → LO updated next edge; rst=0 mid-CALC → HI=LO=0, busy=0, no done.

Source files
------------

// File: rtl/muldiv_sched.sv
// muldiv_sched: owner of the HI/LO pair and sequencer for the iterative
// 32-step multiply (shift-add) and divide (restoring). Signed operations run
// on operand magnitudes and are sign-corrected in a final FIX cycle.
module muldiv_sched (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_alu2Op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_mtEn,
  input  logic        i_mtHi,
  input  logic [31:0] i_mtData,
  input  logic        i_rhlVisit,
  input  logic        i_rhlSelRd,
  input  logic        i_flush,
  output logic [31:0] o_rdData,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  // Operation encodings: bit 1 selects divide, bit 0 selects signed.
  localparam logic [1:0] OP_MULT = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b11;

  state_t      r_state;
  state_t      w_nextState;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_absA;
  logic [31:0] r_absB;
  logic        r_signA;
  logic        r_signB;
  logic [63:0] r_prod;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_done;

  logic        w_signAIn;
  logic        w_signBIn;
  logic [31:0] w_absAIn;
  logic [31:0] w_absBIn;
  logic [63:0] w_addend;
  logic [63:0] w_prodNext;
  logic [4:0]  w_bitIdx;
  logic [32:0] w_remShift;
  logic [32:0] w_trial;
  logic [31:0] w_remNext;
  logic [31:0] w_quotNext;
  logic        w_signsDiffer;
  logic [63:0] w_prodFix;
  logic [31:0] w_quotFix;
  logic [31:0] w_remFix;
  logic        w_commit;

  // Operand magnitudes and signs captured at issue; unsigned ops keep raw values.
  assign w_signAIn = i_alu2Op[0] & i_a[31];
  assign w_signBIn = i_alu2Op[0] & i_b[31];
  assign w_absAIn  = w_signAIn ? -i_a : i_a;
  assign w_absBIn  = w_signBIn ? -i_b : i_b;

  // One shift-add multiply step: add the multiplicand shifted by cnt when multiplier bit[cnt] is set.
  assign w_addend   = {32'b0, r_absA} << r_cnt;
  assign w_prodNext = r_absB[r_cnt] ? (r_prod + w_addend) : r_prod;

  // One restoring-divide step: dividend bits are consumed MSB first.
  assign w_bitIdx   = 5'd31 - r_cnt;
  assign w_remShift = {r_rem, r_absA[w_bitIdx]};
  assign w_trial    = w_remShift - {1'b0, r_absB};
  assign w_remNext  = w_trial[32] ? w_remShift[31:0] : w_trial[31:0];
  assign w_quotNext = w_trial[32] ? r_quot : (r_quot | (32'h1 << w_bitIdx));

  // Sign correction applied in FIX; remainder follows the dividend's sign.
  assign w_signsDiffer = r_signA ^ r_signB;
  assign w_prodFix = ((r_op == OP_MULT) && w_signsDiffer) ? -r_prod : r_prod;
  assign w_quotFix = ((r_op == OP_DIV) && w_signsDiffer) ? -r_quot : r_quot;
  assign w_remFix  = ((r_op == OP_DIV) && r_signA) ? -r_rem : r_rem;

  assign w_commit = (r_state == FIX) && !i_flush;

  // Next-state logic; flush always returns to IDLE and blocks a new issue.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i_start && !i_flush) w_nextState = CALC;
      CALC: begin
        if (i_flush)             w_nextState = IDLE;
        else if (r_cnt == 5'd31) w_nextState = FIX;
      end
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Datapath: operand capture, iteration, MTHI/MTLO writes and the FIX commit.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_cnt   <= 5'd0;
      r_op    <= 2'b00;
      r_absA  <= 32'd0;
      r_absB  <= 32'd0;
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_prod  <= 64'd0;
      r_rem   <= 32'd0;
      r_quot  <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_commit;
      case (r_state)
        IDLE: begin
          if (!i_flush) begin
            if (i_mtEn) begin
              if (i_mtHi) r_hi <= i_mtData;
              else        r_lo <= i_mtData;
            end
            if (i_start) begin
              r_op    <= i_alu2Op;
              r_absA  <= w_absAIn;
              r_absB  <= w_absBIn;
              r_signA <= w_signAIn;
              r_signB <= w_signBIn;
              r_cnt   <= 5'd0;
              r_prod  <= 64'd0;
              r_rem   <= 32'd0;
              r_quot  <= 32'd0;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            r_cnt <= 5'd0;
          end else begin
            r_cnt <= r_cnt + 5'd1;
            if (r_op[1]) begin
              r_rem  <= w_remNext;
              r_quot <= w_quotNext;
            end else begin
              r_prod <= w_prodNext;
            end
          end
        end
        FIX: begin
          r_cnt <= 5'd0;
          if (!i_flush) begin
            if (!r_op[1]) begin
              r_hi <= w_prodFix[63:32];
              r_lo <= w_prodFix[31:0];
            end else if (r_absB != 32'd0) begin
              r_hi <= w_remFix;
              r_lo <= w_quotFix;
            end
          end
        end
        default: r_cnt <= 5'd0;
      endcase
    end
  end

  assign o_hi     = r_hi;
  assign o_lo     = r_lo;
  assign o_rdData = i_rhlSelRd ? r_hi : r_lo;
  assign o_busy   = (r_state != IDLE);
  assign o_stall  = i_rhlVisit & o_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_muldiv_sched.sv
// Testbench for muldiv_sched: directed and random mul/div operations checked
// against an arithmetic reference model of HI/LO, plus timing, flush and reset.
module tb_muldiv_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  alu2Op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        mtEn = 1'b0;
  logic        mtHi = 1'b0;
  logic [31:0] mtData = 32'd0;
  logic        rhlVisit = 1'b0;
  logic        rhlSelRd = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rdData;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  // 10-unit clock period.
  always #5 clk = ~clk;

  muldiv_sched dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_alu2Op   (alu2Op),
    .i_a        (a),
    .i_b        (b),
    .i_mtEn     (mtEn),
    .i_mtHi     (mtHi),
    .i_mtData   (mtData),
    .i_rhlVisit (rhlVisit),
    .i_rhlSelRd (rhlSelRd),
    .i_flush    (flush),
    .o_rdData   (rdData),
    .o_hi       (hi),
    .o_lo       (lo),
    .o_busy     (busy),
    .o_stall    (stall),
    .o_done     (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural effect of a mul/div on HI/LO, from plain arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] p;
    longint sa;
    longint sb;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    case (op)
      2'b00: begin
        p = {32'b0, av} * {32'b0, bv};
        mHi = p[63:32];
        mLo = p[31:0];
      end
      2'b01: begin
        p = 64'(sa * sb);
        mHi = p[63:32];
        mLo = p[31:0];
      end
      2'b10: begin
        if (bv != 32'd0) begin
          mLo = av / bv;
          mHi = av % bv;
        end
      end
      default: begin
        if (bv != 32'd0) begin
          p = 64'(sa / sb);
          mLo = p[31:0];
          p = 64'(sa % sb);
          mHi = p[31:0];
        end
      end
    endcase
  endfunction

  task automatic writeMt(input bit isHi, input logic [31:0] v);
    mtEn = 1'b1;
    mtHi = isHi;
    mtData = v;
    step();
    mtEn = 1'b0;
    if (isHi) begin
      mHi = v;
      checkOutput("mthi", hi, v);
    end else begin
      mLo = v;
      checkOutput("mtlo", lo, v);
    end
  endtask

  // Issue one op (optionally with a simultaneous MTHI) and follow it to completion.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                               input bit withMt, input logic [31:0] mtv);
    int cycles;
    alu2Op = op;
    a = av;
    b = bv;
    start = 1'b1;
    mtEn = withMt;
    mtHi = 1'b1;
    mtData = mtv;
    rhlVisit = 1'b1;
    rhlSelRd = 1'b1;
    step();
    start = 1'b0;
    mtEn = 1'b0;
    a = $urandom;
    b = $urandom;
    if (withMt) begin
      checkOutput("mt_with_start", hi, mtv);
      mHi = mtv;
    end
    refModel(op, av, bv);
    cycles = 0;
    while (busy === 1'b1 && cycles < 60) begin
      cycles++;
      checkOutput("stall_busy", 32'(stall), 32'd1);
      checkOutput("done_early", 32'(done), 32'd0);
      step();
    end
    checkOutput("busy_cycles", cycles, 32'd33);
    checkOutput("stall_after", 32'(stall), 32'd0);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("rd_hi", rdData, mHi);
    rhlSelRd = 1'b0;
    #1;
    checkOutput("rd_lo", rdData, mLo);
    checkOutput("hi", hi, mHi);
    checkOutput("lo", lo, mLo);
    rhlVisit = 1'b0;
    step();
    checkOutput("done_once", 32'(done), 32'd0);
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    $display("[TB] reset");
    rst = 1'b0;
    step();
    step();
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    rhlVisit = 1'b1;
    #1;
    checkOutput("idle_stall", 32'(stall), 32'd0);
    rhlVisit = 1'b0;

    $display("[TB] directed operations");
    applyStimulus(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd0);
    checkOutput("multu_hi_const", hi, 32'hFFFFFFFE);
    checkOutput("multu_lo_const", lo, 32'h00000001);
    applyStimulus(2'b01, 32'hFFFFFFFD, 32'd5, 1'b0, 32'd0);
    checkOutput("mult_hi_const", hi, 32'hFFFFFFFF);
    checkOutput("mult_lo_const", lo, 32'hFFFFFFF1);
    applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, 32'd0);
    checkOutput("div_lo_const", lo, 32'hFFFFFFFD);
    checkOutput("div_hi_const", hi, 32'hFFFFFFFF);

    $display("[TB] divide by zero and overflow");
    writeMt(1'b1, 32'h11);
    writeMt(1'b0, 32'h22);
    applyStimulus(2'b10, 32'd100, 32'd0, 1'b0, 32'd0);
    checkOutput("div0_hi", hi, 32'h11);
    checkOutput("div0_lo", lo, 32'h22);
    applyStimulus(2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0);
    checkOutput("ovf_lo", lo, 32'h80000000);
    checkOutput("ovf_hi", hi, 32'h0);

    $display("[TB] start with simultaneous MTHI");
    applyStimulus(2'b10, 32'd1000, 32'd7, 1'b1, 32'h1234ABCD);

    $display("[TB] random operations");
    for (int i = 0; i < 8; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA = $urandom;
      case ($urandom_range(0, 7))
        0:       rB = 32'd0;
        1, 2:    rB = 32'($urandom_range(1, 1000));
        default: rB = $urandom;
      endcase
      applyStimulus(rOp, rA, rB, 1'b0, 32'd0);
    end

    $display("[TB] flush in CALC");
    alu2Op = 2'b01;
    a = 32'h00012345;
    b = 32'hFFFF0001;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    checkOutput("busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    start = 1'b1;
    step();
    flush = 1'b0;
    start = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_done", 32'(done), 32'd0);
    checkOutput("flush_hi", hi, mHi);
    checkOutput("flush_lo", lo, mLo);
    step();
    checkOutput("flush_busy2", 32'(busy), 32'd0);
    checkOutput("flush_done2", 32'(done), 32'd0);

    $display("[TB] start with flush in IDLE");
    flush = 1'b1;
    start = 1'b1;
    step();
    flush = 1'b0;
    start = 1'b0;
    checkOutput("idle_flush_busy", 32'(busy), 32'd0);

    $display("[TB] MTLO");
    writeMt(1'b0, 32'hDEADBEEF);

    $display("[TB] reset mid-CALC");
    alu2Op = 2'b10;
    a = 32'd999;
    b = 32'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    mHi = 32'd0;
    mLo = 32'd0;
    checkOutput("midrst_hi", hi, mHi);
    checkOutput("midrst_lo", lo, mLo);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    repeat (40) begin
      step();
      checkOutput("midrst_no_done", 32'(done), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
